// File: rtl/scan_dff_bank.sv
// Scannable register bank: functional load, sync set, manual shift and an autonomous WIDTH-cycle shift sequencer.
// Latency: Q updates one edge after the controlling input; SCAN_BUSY rises one edge after an accepted SCAN_START.
// Backpressure: none; SCAN_START is only sampled in IDLE, so requests made while busy or done are dropped.
module scan_dff_bank #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             SETN,
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
    input  logic             SCAN_START,
    output logic             SCAN_BUSY,
    output logic             SCAN_DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    localparam int CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [CntW-1:0]   shiftCnt;
    logic [WIDTH-1:0]  qReg;
    logic [WIDTH-1:0]  shifted;

    // Written bitwise so a single-bit bank degenerates to Q <= SI without a negative slice.
    always_comb begin
        shifted    = qReg << 1;
        shifted[0] = SI;
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            qReg     <= RESET_VAL;
            state    <= IDLE;
            shiftCnt <= '0;
        end else if (!SETN) begin
            // Set also aborts any running sequence; DONE is skipped so no completion pulse.
            qReg     <= SET_VAL;
            state    <= IDLE;
            shiftCnt <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    qReg <= shifted;
                    if (shiftCnt == '0) begin
                        state <= DONE;
                    end else begin
                        shiftCnt <= shiftCnt - 1'b1;
                    end
                end
                default: begin
                    if (SE) begin
                        qReg <= shifted;
                    end else if (EN) begin
                        qReg <= D;
                    end
                    if (state == IDLE && SCAN_START) begin
                        state    <= SHIFT;
                        shiftCnt <= CntW'(WIDTH - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign Q         = qReg;
    assign QN        = ~qReg;
    assign SO        = qReg[WIDTH-1];
    assign SCAN_BUSY = (state == SHIFT);
    assign SCAN_DONE = (state == DONE);

endmodule

// File: tb/tb_scan_dff_bank.sv
// Bench for scan_dff_bank: directed scenarios plus randomized traffic against a sequence-length model, WIDTH=8 and WIDTH=1.
module tb_scan_dff_bank;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance stimulus / observation
    logic       rn = 1'b0, setn = 1'b1, se = 1'b0, si = 1'b0, en = 1'b0, start = 1'b0;
    logic [7:0] d = '0;
    logic       so8, busy8, done8;
    logic [7:0] q8, qn8;

    // WIDTH=1 instance stimulus / observation
    logic       rn1 = 1'b0, setn1 = 1'b1, se1 = 1'b0, si1 = 1'b0, en1 = 1'b0, start1 = 1'b0;
    logic [0:0] d1 = '0;
    logic       so1, busy1, done1;
    logic [0:0] q1, qn1;

    scan_dff_bank #(.WIDTH(8)) u8 (
        .CK(clk), .RN(rn), .D(d), .EN(en), .SETN(setn), .SE(se), .SI(si), .SO(so8),
        .SCAN_START(start), .SCAN_BUSY(busy8), .SCAN_DONE(done8), .Q(q8), .QN(qn8)
    );

    scan_dff_bank #(.WIDTH(1)) u1 (
        .CK(clk), .RN(rn1), .D(d1), .EN(en1), .SETN(setn1), .SE(se1), .SI(si1), .SO(so1),
        .SCAN_START(start1), .SCAN_BUSY(busy1), .SCAN_DONE(done1), .Q(q1), .QN(qn1)
    );

    int passCnt  = 0;
    int totalCnt = 0;
    bit checkEn  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Model: register value plus number of cycles still to go in an autonomous sequence
    // (WIDTH busy cycles followed by one done cycle; 0 means idle).
    typedef struct {
        longint q;
        int     seqLeft;
    } mst_t;

    function automatic mst_t mstep(mst_t s, int w, bit r, bit st, bit sen, bit sin,
                                   bit ena, bit go, longint dat);
        longint mask = (64'd1 << w) - 1;
        bit     wasIdle;
        if (!r) begin
            s.q = 0;
            s.seqLeft = 0;
        end else if (!st) begin
            s.q = mask;
            s.seqLeft = 0;
        end else if (s.seqLeft > 1) begin
            s.q = ((s.q << 1) | longint'(sin)) & mask;
            s.seqLeft--;
        end else begin
            wasIdle = (s.seqLeft == 0);
            s.seqLeft = 0;
            if (sen) s.q = ((s.q << 1) | longint'(sin)) & mask;
            else if (ena) s.q = dat & mask;
            if (wasIdle && go) s.seqLeft = w + 1;
        end
        return s;
    endfunction

    mst_t m8 = '{q: 0, seqLeft: 0};
    mst_t m1 = '{q: 0, seqLeft: 0};

    always @(posedge clk) begin
        m8 = mstep(m8, 8, rn, setn, se, si, en, start, longint'(d));
        m1 = mstep(m1, 1, rn1, setn1, se1, si1, en1, start1, longint'(d1));
    end

    always @(negedge clk) begin
        if (checkEn) begin
            totalCnt++;
            if (longint'(q8) == m8.q && qn8 == ~q8 && so8 == m8.q[7] &&
                busy8 == (m8.seqLeft > 1) && done8 == (m8.seqLeft == 1))
                passCnt++;
            else
                $display("FAIL w8_cycle t=%0t: q=%h qn=%h so=%b busy=%b done=%b expected q=%h so=%b busy=%b done=%b",
                         $time, q8, qn8, so8, busy8, done8, m8.q[7:0], m8.q[7],
                         m8.seqLeft > 1, m8.seqLeft == 1);
            totalCnt++;
            if (longint'(q1) == m1.q && qn1 == ~q1 && so1 == m1.q[0] &&
                busy1 == (m1.seqLeft > 1) && done1 == (m1.seqLeft == 1))
                passCnt++;
            else
                $display("FAIL w1_cycle t=%0t: q=%b qn=%b so=%b busy=%b done=%b expected q=%b busy=%b done=%b",
                         $time, q1, qn1, so1, busy1, done1, m1.q[0],
                         m1.seqLeft > 1, m1.seqLeft == 1);
        end
    end

    // Advance one edge; inputs driven afterwards change 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] soSeq;
        logic [8:0] busyPat;
        int         busyCnt;
        bit         sawDone;

        // Reset with junk on every other input
        d = 8'h5B; en = 1'b1; setn = 1'b0; se = 1'b1; si = 1'b1; start = 1'b1;
        d1 = 1'b1; en1 = 1'b1; setn1 = 1'b0; se1 = 1'b1; si1 = 1'b1; start1 = 1'b1;
        step();
        checkEn = 1'b1;
        step();
        chk("reset_q", q8, 8'h00);
        chk("reset_qn", qn8, 8'hFF);
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_q_w1", q1, 0);

        rn = 1'b1; setn = 1'b1; se = 1'b0; start = 1'b0; en = 1'b1; d = 8'hA5;
        rn1 = 1'b1; setn1 = 1'b1; se1 = 1'b0; start1 = 1'b0; en1 = 1'b0;
        step();
        chk("load_q", q8, 8'hA5);
        chk("load_qn", qn8, 8'h5A);

        // Priority: set over shift/load, reset over set
        d = 8'h3C; step();
        chk("prio_pre", q8, 8'h3C);
        setn = 1'b0; en = 1'b1; d = 8'h00; se = 1'b1; step();
        chk("prio_set", q8, 8'hFF);
        rn = 1'b0; step();
        chk("prio_reset", q8, 8'h00);
        rn = 1'b1; setn = 1'b1; se = 1'b0;

        // Manual scan
        en = 1'b1; d = 8'h81; step();
        chk("man_so_before", so8, 1);
        en = 1'b0; se = 1'b1; si = 1'b0; step();
        chk("man_shift_q", q8, 8'h02);
        chk("man_so_after", so8, 0);
        en = 1'b1; d = 8'hFF; si = 1'b1; step();
        chk("man_shift_wins", q8, 8'h05);
        se = 1'b0; en = 1'b0;

        // Autonomous scan from 0xC3 with SI = 1,0,1,0,...
        en = 1'b1; d = 8'hC3; step();
        en = 1'b0; start = 1'b1; step();
        start = 1'b0;
        busyCnt = 0; soSeq = '0;
        for (int i = 0; i < 12 && busy8; i++) begin
            soSeq = {soSeq[6:0], so8};
            si = (busyCnt % 2 == 0);
            en = 1'b1; d = 8'($urandom);
            busyCnt++;
            step();
        end
        en = 1'b0;
        chk("auto_busy_cycles", busyCnt, 8);
        chk("auto_so_seq", soSeq, 8'b1100_0011);
        chk("auto_final_q", q8, 8'hAA);
        chk("auto_model_q", m8.q, 8'hAA);
        chk("auto_done_pulse", done8, 1);
        chk("auto_busy_low", busy8, 0);
        step();
        chk("auto_done_single", done8, 0);
        chk("auto_hold_q", q8, 8'hAA);

        // Abort with set after 3 shifts
        en = 1'b1; d = 8'hC3; step();
        en = 1'b0; si = 1'b0; start = 1'b1; step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("abort_set_mid_q", q8, 8'h18);
        setn = 1'b0; step();
        setn = 1'b1;
        chk("abort_set_q", q8, 8'hFF);
        chk("abort_set_busy", busy8, 0);
        sawDone = done8;
        for (int i = 0; i < 3; i++) begin step(); sawDone |= done8; end
        chk("abort_set_no_done", sawDone, 0);

        // Abort with reset at shift 5
        start = 1'b1; step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rn = 1'b0; step();
        rn = 1'b1;
        chk("abort_rst_q", q8, 8'h00);
        chk("abort_rst_busy", busy8, 0);
        sawDone = done8;
        for (int i = 0; i < 3; i++) begin step(); sawDone |= done8; end
        chk("abort_rst_no_done", sawDone, 0);

        // Set and start together in idle: set wins, no sequence
        setn = 1'b0; start = 1'b1; step();
        setn = 1'b0; start = 1'b0;
        chk("set_vs_start_q", q8, 8'hFF);
        chk("set_vs_start_busy", busy8, 0);
        setn = 1'b1; step();
        chk("set_vs_start_idle", busy8, 0);

        // WIDTH=1 single sequence
        start1 = 1'b1; si1 = 1'b1; step();
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        step();
        chk("w1_q", q1, 1);
        chk("w1_done", done1, 1);
        chk("w1_busy_low", busy1, 0);
        step();
        chk("w1_done_single", done1, 0);

        // WIDTH=1 with start held: busy 1 cycle, then 2-cycle gap
        start1 = 1'b1;
        busyPat = '0;
        for (int i = 0; i < 9; i++) begin
            si1 = 1'($urandom);
            step();
            busyPat = {busyPat[7:0], busy1};
        end
        start1 = 1'b0;
        chk("w1_held_pattern", busyPat, 9'b100_100_100);
        step(); step(); step();

        // Randomized traffic on both instances
        for (int i = 0; i < 4000; i++) begin
            rn     = ($urandom_range(63) != 0);
            setn   = ($urandom_range(31) != 0);
            se     = ($urandom_range(3) == 0);
            en     = 1'($urandom);
            si     = 1'($urandom);
            start  = ($urandom_range(7) == 0);
            d      = 8'($urandom);
            rn1    = ($urandom_range(63) != 0);
            setn1  = ($urandom_range(31) != 0);
            se1    = ($urandom_range(3) == 0);
            en1    = 1'($urandom);
            si1    = 1'($urandom);
            start1 = ($urandom_range(3) == 0);
            d1     = 1'($urandom);
            step();
        end

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
